// File: rtl/memories_pkg.sv
// Shared memory-subsystem types: per-request status and the backing store FSM states.
package memories_pkg;

  typedef enum logic [1:0] {
    MEMORY_ACCESS_OK           = 2'd0,
    MEMORY_WAIT_READY          = 2'd1,
    MEMORY_ERROR_OUT_OF_BOUNDS = 2'd2
  } memory_status_t;

  typedef enum logic [1:0] {
    BS_IDLE  = 2'd0,
    BS_CAS   = 2'd1,
    BS_BURST = 2'd2
  } bs_state_t;

endpackage

// File: rtl/burst_address_gen.sv
// Critical-word-first wrapping burst address: base of the aligned burst plus (offset + beat) mod B.
module burst_address_gen #(
  parameter int AW = 16,
  parameter int BW = 3
) (
  input  logic [AW-1:0] base,
  input  logic [BW-1:0] offset,
  input  logic [BW-1:0] beat,
  output logic [AW-1:0] addr
);

  logic [BW-1:0] wrapped_index;

  // BW-bit addition wraps naturally, so the burst never leaves its aligned block
  assign wrapped_index = offset + beat;
  assign addr          = (base & ~AW'((1 << BW) - 1)) | AW'(wrapped_index);

endmodule

// File: rtl/backing_store_model.sv
// DRAM-style backing store: CAS latency, then B critical-word-first wrapping beats per request.
module backing_store_model
  import memories_pkg::*;
#(
  parameter int backing_store_latency      = 3,
  parameter int backing_store_word_size    = 2,
  parameter int backing_store_word_count   = 2**16,
  parameter int backing_store_burst_amount = 8,
  localparam int AW = $clog2(backing_store_word_count),
  localparam int DW = 8 * backing_store_word_size,
  localparam int BW = $clog2(backing_store_burst_amount),
  localparam int LW = $clog2(backing_store_latency + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           backing_store_req,
  output logic           backing_store_ready,
  input  logic           backing_store_we,
  input  logic [AW-1:0]  backing_store_address,
  input  logic [DW-1:0]  backing_store_wdata,
  output logic           backing_store_wstrobe,
  output logic [DW-1:0]  backing_store_rdata,
  output logic           backing_store_drdy,
  output memory_status_t backing_store_status,
  output logic           backing_store_busy
);

  localparam logic [AW:0]   WORD_LIMIT = (AW + 1)'(backing_store_word_count);
  localparam logic [AW:0]   BURST_SPAN = (AW + 1)'(backing_store_burst_amount);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(backing_store_burst_amount - 1);

  if (backing_store_latency < 1) begin : g_bad_latency
    $error("backing_store_latency must be at least 1");
  end
  if (backing_store_burst_amount < 2 ||
      (backing_store_burst_amount & (backing_store_burst_amount - 1)) != 0) begin : g_bad_burst
    $error("backing_store_burst_amount must be a power of 2 and at least 2");
  end

  bs_state_t      state_reg, state_next;
  memory_status_t status_reg, status_next;
  logic [AW-1:0]  base_reg, base_next;
  logic [BW-1:0]  offset_reg, offset_next;
  logic [BW-1:0]  beat_reg, beat_next;
  logic [LW-1:0]  lat_reg, lat_next;
  logic           we_reg, we_next;
  logic           oob_reg, oob_next;
  logic           drdy_reg, drdy_next;
  logic           wstrobe_reg, wstrobe_next;
  logic           rzero_reg, rzero_next;

  logic [AW-1:0]  in_base;
  logic [AW-1:0]  gen_base;
  logic [BW-1:0]  gen_offset, gen_beat;
  logic [AW-1:0]  mem_addr;
  logic           accept, req_in_range, burst_partial, addr_in_range;
  logic           rd_en, wr_en;

  logic [DW-1:0]  mem [backing_store_word_count];
  logic [DW-1:0]  mem_q;

  assign accept        = (state_reg == BS_IDLE) && backing_store_req;
  assign in_base       = backing_store_address & ~AW'(backing_store_burst_amount - 1);
  assign req_in_range  = {1'b0, backing_store_address} < WORD_LIMIT;
  assign burst_partial = ({1'b0, in_base} + BURST_SPAN) > WORD_LIMIT;
  assign addr_in_range = {1'b0, mem_addr} < WORD_LIMIT;

  burst_address_gen #(
    .AW (AW),
    .BW (BW)
  ) u_addr_gen (
    .base   (gen_base),
    .offset (gen_offset),
    .beat   (gen_beat),
    .addr   (mem_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= BS_IDLE;
      status_reg  <= MEMORY_ACCESS_OK;
      base_reg    <= '0;
      offset_reg  <= '0;
      beat_reg    <= '0;
      lat_reg     <= '0;
      we_reg      <= 1'b0;
      oob_reg     <= 1'b0;
      drdy_reg    <= 1'b0;
      wstrobe_reg <= 1'b0;
      rzero_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      status_reg  <= status_next;
      base_reg    <= base_next;
      offset_reg  <= offset_next;
      beat_reg    <= beat_next;
      lat_reg     <= lat_next;
      we_reg      <= we_next;
      oob_reg     <= oob_next;
      drdy_reg    <= drdy_next;
      wstrobe_reg <= wstrobe_next;
      rzero_reg   <= rzero_next;
    end
  end

  // Reads are issued one edge ahead of their beat (registered rdata); writes land at the end of theirs.
  always_comb begin
    state_next   = state_reg;
    status_next  = status_reg;
    base_next    = base_reg;
    offset_next  = offset_reg;
    beat_next    = beat_reg;
    lat_next     = lat_reg;
    we_next      = we_reg;
    oob_next     = oob_reg;
    drdy_next    = 1'b0;
    wstrobe_next = 1'b0;
    rd_en        = 1'b0;
    gen_base     = base_reg;
    gen_offset   = offset_reg;
    gen_beat     = beat_reg;

    case (state_reg)
      BS_IDLE: begin
        status_next = MEMORY_ACCESS_OK;
        gen_base    = in_base;
        gen_offset  = backing_store_address[BW-1:0];
        gen_beat    = '0;
        if (accept) begin
          if (!req_in_range) begin
            status_next = MEMORY_ERROR_OUT_OF_BOUNDS;
          end else begin
            status_next = MEMORY_WAIT_READY;
            base_next   = in_base;
            offset_next = backing_store_address[BW-1:0];
            we_next     = backing_store_we;
            oob_next    = burst_partial;
            beat_next   = '0;
            lat_next    = LW'(backing_store_latency - 1);
            if (backing_store_latency == 1) begin
              state_next   = BS_BURST;
              drdy_next    = !backing_store_we;
              wstrobe_next = backing_store_we;
              rd_en        = !backing_store_we;
            end else begin
              state_next = BS_CAS;
            end
          end
        end
      end

      BS_CAS: begin
        lat_next = lat_reg - LW'(1);
        gen_beat = '0;
        if (lat_reg == LW'(1)) begin
          state_next   = BS_BURST;
          beat_next    = '0;
          drdy_next    = !we_reg;
          wstrobe_next = we_reg;
          rd_en        = !we_reg;
        end
      end

      BS_BURST: begin
        gen_beat  = we_reg ? beat_reg : beat_reg + BW'(1);
        beat_next = beat_reg + BW'(1);
        if (beat_reg == LAST_BEAT) begin
          state_next  = BS_IDLE;
          status_next = oob_reg ? MEMORY_ERROR_OUT_OF_BOUNDS : MEMORY_ACCESS_OK;
        end else begin
          drdy_next    = !we_reg;
          wstrobe_next = we_reg;
          rd_en        = !we_reg;
        end
      end

      default: state_next = BS_IDLE;
    endcase
  end

  // Out-of-range read beats show zero rather than stale array output
  assign rzero_next = rd_en ? !addr_in_range : rzero_reg;
  assign wr_en      = wstrobe_reg && addr_in_range;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[mem_addr] <= backing_store_wdata;
    end
    if (rd_en && addr_in_range) begin
      mem_q <= mem[mem_addr];
    end
  end

  assign backing_store_ready   = (state_reg == BS_IDLE);
  assign backing_store_busy    = (state_reg != BS_IDLE);
  assign backing_store_drdy    = drdy_reg;
  assign backing_store_wstrobe = wstrobe_reg;
  assign backing_store_status  = status_reg;
  assign backing_store_rdata   = rzero_reg ? '0 : mem_q;

endmodule
